countdown_arbiter: RTL and testbench
====================================

COUNTDOWN_ARBITER -- requirements
Module: countdown_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0  input  1  requester 0 asks for the shared down-counter; level-sensitive.
REQ-005 len0  input  4  requester 0 countdown start value, sampled only at the grant edge.
REQ-006 req1  input  1  requester 1 asks for the shared down-counter; level-sensitive.
REQ-007 len1  input  4  requester 1 countdown start value, sampled only at the grant edge.
REQ-008 gnt0, gnt1  output  1 each  owner indication; high while the owner's countdown runs; never both high.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse to the owner.
REQ-010 busy  output  1  high when the state is not IDLE.
REQ-011 count  output  4  current value of the shared 4-bit down-counter.

Function
REQ-012 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 IDLE, no request: SHALL stay in IDLE with count=0 and all grants/dones low.
REQ-014 IDLE, any request: at the edge, SHALL enter RUN, assert the winner's gnt, and load count from the winner's len.
REQ-015 Arbitration SHALL be round-robin: if both request, the one not granted last wins; after reset requester 0 has priority.
REQ-016 RUN with count!=0: each edge SHALL decrement count by 1; gnt holds; no wrap-around.
REQ-017 RUN with count==0: the edge SHALL enter DONE, drop gnt and pulse the owner's done for exactly one cycle; count stays 0.
REQ-018 DONE: the next edge SHALL return to IDLE unconditionally; arbitration resumes from IDLE.
REQ-019 Timing: a grant taken at edge N keeps gnt high for len+1 cycles, with done high during the cycle after edge N+len+1; len=0 gives gnt for 1 cycle.
REQ-020 Requests, and len changes from the non-owner, during RUN/DONE SHALL be ignored; len changes from the owner after the grant edge SHALL be ignored.
REQ-021 The last-granted pointer SHALL update only at the grant edge.

Reset
REQ-022 rst high at an edge SHALL force IDLE, count=0, gnt0=gnt1=0, done0=done1=0, busy=0, priority to requester 0, from any state including mid-RUN; rst has priority over all other inputs.
REQ-023 Reset mid-RUN SHALL NOT produce a done pulse.

Configuration
REQ-024 Macro COUNTDOWN_ABORT_EN defined: the owner deasserting its req during RUN SHALL, at that edge, return the block to IDLE with count=0, gnt low and no done pulse; the last-granted pointer keeps the aborted owner.
REQ-025 Macro COUNTDOWN_ABORT_EN undefined: the owner's req SHALL be ignored after the grant edge and the countdown always runs to DONE.

Verification
REQ-026 rst for 2 cycles, then release with req0=req1=0 -> count=0, busy=0, all gnt/done low and held.
REQ-027 req0=1, len0=3 for one cycle from IDLE -> gnt0 high 4 cycles with count 3,2,1,0, then done0 high 1 cycle, then IDLE.
REQ-028 req0=req1=1 held, len0=1, len1=2 -> grant order 0,1,0,1; each done pulses once per grant; gnt0 and gnt1 never both high.
REQ-029 req1=1, len1=0 -> gnt1 high 1 cycle with count=0, then done1 pulse, busy low 2 cycles after the grant edge.
REQ-030 req0=1, len0=9; rst pulsed when count=5 -> next cycle IDLE, count=0, no done0; both request next -> requester 0 granted.
REQ-031 With COUNTDOWN_ABORT_EN: req0 drops when count=4 -> next cycle IDLE, gnt0 low, no done0. Without the macro: the countdown completes with done0.

Source files
------------

// File: rtl/countdown_arbiter.sv
// Two-requester round-robin arbiter that grants a shared 4-bit down-counter.
// Optional macro COUNTDOWN_ABORT_EN: owner dropping req during RUN aborts to IDLE.
module countdown_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] len0,
    input  logic       req1,
    input  logic [3:0] len1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic [3:0] count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;
    logic   owner;      // 0: requester 0 holds the counter, 1: requester 1
    logic   last;       // last granted requester; the other one wins a tie
    logic   any_req;
    logic   win;
    logic   abort;

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) win = ~last;
        else              win = req1;
    end

`ifdef COUNTDOWN_ABORT_EN
    logic owner_req;
    always_comb begin
        owner_req = owner ? req1 : req0;
        abort     = (state == RUN) && !owner_req;
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = RUN;
            RUN: begin
                if (abort)              state_nxt = IDLE;
                else if (count == 4'd0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter, owner and round-robin pointer; len and pointer only move at the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    count <= win ? len1 : len0;
                    owner <= win;
                    last  <= win;
                end
                RUN: begin
                    if (abort)              count <= 4'd0;
                    else if (count != 4'd0) count <= count - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt0  = (state == RUN)  && !owner;
        gnt1  = (state == RUN)  &&  owner;
        done0 = (state == DONE) && !owner;
        done1 = (state == DONE) &&  owner;
        busy  = (state != IDLE);
    end

endmodule

// File: tb/tb_countdown_arbiter.sv
// Scoreboard bench for countdown_arbiter: a transaction-level model expands each
// grant into its expected per-cycle outputs; a monitor pops and compares them.
module tb_countdown_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] len0 = 4'd0, len1 = 4'd0;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [3:0] count;

    countdown_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .len0(len0), .req1(req1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       g0, g1, d0, d1, bz;
        logic [3:0] cnt;
    } rec_t;

    rec_t expq[$];
    rec_t plan[$];
    rec_t cur = '0;
    bit   prio1 = 1'b0;     // 1 when requester 1 wins a tie
    int   checks = 0;
    int   errors = 0;

    function automatic rec_t mk(bit g0, bit g1, bit d0, bit d1, bit bz, logic [3:0] c);
        rec_t r;
        r.g0 = g0; r.g1 = g1; r.d0 = d0; r.d1 = d1; r.bz = bz; r.cnt = c;
        return r;
    endfunction

    // Apply one cycle of inputs and predict the outputs after the next rising edge.
    task automatic cyc(input bit r, input bit a0, input logic [3:0] l0,
                       input bit a1, input logic [3:0] l1);
        rec_t nx;
        bit   ab, w;
        int   l;
        @(negedge clk);
        rst = r; req0 = a0; len0 = l0; req1 = a1; len1 = l1;
        if (r) begin
            plan.delete();
            prio1 = 1'b0;
            nx = '0;
        end else if (cur.g0 || cur.g1) begin
            ab = 1'b0;
`ifdef COUNTDOWN_ABORT_EN
            ab = cur.g0 ? !a0 : !a1;
`endif
            if (ab) begin
                plan.delete();
                nx = '0;
            end else begin
                nx = plan.pop_front();
            end
        end else if (cur.d0 || cur.d1 || !(a0 || a1)) begin
            nx = '0;
        end else begin
            w = (a0 && a1) ? prio1 : a1;
            prio1 = !w;
            l = w ? int'(l1) : int'(l0);
            for (int k = l; k >= 0; k--) plan.push_back(mk(!w, w, 1'b0, 1'b0, 1'b1, 4'(k)));
            plan.push_back(mk(1'b0, 1'b0, !w, w, 1'b1, 4'd0));
            nx = plan.pop_front();
        end
        cur = nx;
        expq.push_back(nx);
    endtask

    initial begin : monitor
        rec_t e, a;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = mk(gnt0, gnt1, done0, done1, busy, count);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got g0=%b g1=%b d0=%b d1=%b busy=%b cnt=%0d exp g0=%b g1=%b d0=%b d1=%b busy=%b cnt=%0d",
                             $time, a.g0, a.g1, a.d0, a.d1, a.bz, a.cnt,
                             e.g0, e.g1, e.d0, e.d1, e.bz, e.cnt);
                end
                checks++;
                if (gnt0 && gnt1) begin
                    errors++;
                    $display("FAIL both_gnt t=%0t got gnt0=%b gnt1=%b exp not both high", $time, gnt0, gnt1);
                end
            end
        end
    end

    initial begin : stim
        // reset for two cycles, then idle
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        // single request, len 3
        cyc(0, 1, 3, 0, 0);
        repeat (6) cyc(0, 0, 4'd7, 0, 0);
        // both held: alternating grants
        repeat (16) cyc(0, 1, 1, 1, 2);
        repeat (4) cyc(0, 0, 0, 0, 0);
        // len 0 on requester 1
        cyc(0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        // reset mid-run at count 5, then a tie goes to requester 0
        cyc(0, 1, 9, 0, 0);
        repeat (4) cyc(0, 1, 9, 0, 0);
        cyc(1, 1, 9, 0, 0);
        cyc(0, 1, 4, 1, 4);
        repeat (8) cyc(0, 0, 0, 0, 0);
        // owner drops req at count 4
        cyc(0, 1, 8, 0, 0);
        repeat (4) cyc(0, 1, 8, 0, 0);
        cyc(0, 0, 8, 0, 0);
        repeat (12) cyc(0, 0, 0, 0, 0);
        // random traffic with occasional reset
        repeat (3000) begin
            cyc($urandom_range(0, 59) == 0,
                $urandom_range(0, 2) != 0, 4'($urandom),
                $urandom_range(0, 2) != 0, 4'($urandom));
        end
        repeat (20) cyc(0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
